month_walker: RTL and testbench
===============================

# month_walker

Sequential controller for the weekday-offset datapath. It accepts one start request (date, month, weekday, record count) over a valid/ready handshake and validates it. It then walks forward month by month, emitting one record per month with the weekday on which the same date falls, over a valid/ready output stream. It sits between a request source, such as a host register file or test driver, and any consumer of per-month weekday results. It replaces one-shot two-month lookups with an arbitrary-length sequenced walk.

## Interface
Parameters:
- none; widths are fixed by the calendar encoding.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  start request present.
- start_ready  out  1  block idle; request accepted on start_valid && start_ready.
- start_date  in  5  day of month, legal 1..31.
- start_mon  in  4  month, legal 1..12.
- start_week  in  3  weekday of start date, 0..6; 7 is illegal.
- start_count  in  4  number of records to emit including the start month, legal 1..15.
- out_valid  out  1  record present.
- out_ready  in  1  consumer accepts the record on out_valid && out_ready.
- out_mon  out  4  month of the current record.
- out_week  out  3  weekday of start_date in out_mon.
- out_skip  out  1  start_date does not exist in out_mon (for example day 31 in February).
- out_last  out  1  final record of the walk.
- err  out  1  one-cycle pulse: request rejected.

## Operation
- FSM states: IDLE, CHECK, EMIT.
  - IDLE: start_ready=1.
  - On accept, register date, mon, week and count, then go to CHECK.
- CHECK (one cycle) rejects the request if any of the following hold:
  - mon ∉ 1..12;
  - date = 0 or date > days_in(mon);
  - week = 7;
  - count = 0.
- CHECK outcome:
  - Reject: err=1 for the next cycle, return to IDLE, no out_valid.
  - Accept: go to EMIT with remaining=count.
- EMIT presents the current record:
  - out_mon = current month, out_week = current weekday;
  - out_skip = (date > days_in(current month));
  - out_last = (remaining == 1).
- On an output handshake in EMIT:
  - If out_last=1, go to IDLE.
  - Otherwise advance: month ← next(month), weekday ← (weekday + offset(month)) mod 7, remaining ← remaining − 1.
- Calendar arithmetic:
  - offset(m) is 3 for 31-day months, 2 for 30-day months, 0 for February. Leap years are not modelled; February has 28 days.
  - next(12) = 1; the walk wraps freely across years.
  - The weekday always advances by the offset of the month being left, even when the record was skipped.
- The first record is the start month itself: week = start_week, skip = 0.

## Timing
- Reset (async): state=IDLE; start_ready=1; out_valid, out_skip, out_last and err = 0; out_mon=0; out_week=0; remaining=0. Reset mid-walk aborts immediately; no further records are emitted.
- Latency from accept at edge k:
  - CHECK occupies cycle k+1.
  - First out_valid, or the err pulse, appears in cycle k+2.
- Throughput: one record per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_mon, out_week, out_skip and out_last stay stable and out_valid stays high.
- start_ready=0 in CHECK and EMIT; start_valid is ignored while busy.
- start_ready returns to 1 in the cycle after the last output handshake, or the cycle after the err pulse. The err pulse and start_ready=1 are in the same cycle.
- err and out_valid are never high together.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Structure
- Shared package `cal_pkg`:
  - days_in_month(mon) → 5-bit value;
  - month_offset(mon) → 3-bit value;
  - next_month(mon) → 4-bit value;
  - constants WEEK_INVALID=3'd7 and MON_DEC=4'd12.
- One sub-module `month_step`, combinational: (mon, week) → (next_mon, next_week), with the mod-7 reduction done by conditional subtract of 7.
- month_walker holds the FSM, capture registers, remaining counter and output registers. Target size is about 150–250 lines.

## Test plan
- Basic walk: date 15, mon 1, week 3, count 3 → (1,3,skip0), (2,6,skip0), (3,6,skip0,last); first out_valid 2 cycles after accept.
- Year wrap: date 10, mon 11, week 0, count 3 → (11,0), (12,2), (1,5,last).
- Skip: date 31, mon 1, week 1, count 3 → (1,1,0), (2,4,skip1), (3,4,0,last).
- Rejects: each of mon=13, date=31 with mon=4, week=7, and count=0 → single-cycle err 2 cycles after accept, no out_valid, start_ready=1 in the same cycle as err.
- Backpressure/busy: hold out_ready low for 3 cycles on record 2 → outputs stable, no advance; start_valid pulsed while busy → ignored.
- Reset mid-walk: assert rst during record 2 → all outputs 0 and start_ready=1; after release a fresh request walks correctly.

Source files
------------

// File: rtl/cal_pkg.sv
// Calendar helpers shared by the month walker: non-leap month lengths,
// the weekday shift caused by each month, and month succession.
package cal_pkg;

  localparam logic [2:0] WEEK_INVALID = 3'd7;
  localparam logic [3:0] MON_DEC      = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Illegal month codes report zero days so any date fails the range test.
  function automatic logic [4:0] days_in_month(input logic [3:0] mon);
    case (mon)
      4'd2:                          days_in_month = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:       days_in_month = 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7,
      4'd8, 4'd10, 4'd12:            days_in_month = 5'd31;
      default:                       days_in_month = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] month_offset(input logic [3:0] mon);
    case (days_in_month(mon))
      5'd31:   month_offset = 3'd3;
      5'd30:   month_offset = 3'd2;
      default: month_offset = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] next_month(input logic [3:0] mon);
    next_month = (mon == MON_DEC) ? 4'd1 : mon + 4'd1;
  endfunction

endpackage

// File: rtl/month_step.sv
// One calendar step: the following month and the weekday the same date
// lands on there, given the month being left and its weekday.
module month_step
  import cal_pkg::*;
(
  input  logic [3:0] mon_i,
  input  logic [2:0] week_i,
  output logic [3:0] next_mon_o,
  output logic [2:0] next_week_o
);

  logic [3:0] sum;

  // week <= 6 and offset <= 3, so one conditional subtract reduces mod 7.
  assign sum         = {1'b0, week_i} + {1'b0, month_offset(mon_i)};
  assign next_mon_o  = next_month(mon_i);
  assign next_week_o = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];

endmodule

// File: rtl/month_walker.sv
// Accepts one start request, validates it, then streams one weekday record
// per month until the requested count is exhausted.
module month_walker
  import cal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [4:0] start_date,
  input  logic [3:0] start_mon,
  input  logic [2:0] start_week,
  input  logic [3:0] start_count,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_mon,
  output logic [2:0] out_week,
  output logic       out_skip,
  output logic       out_last,
  output logic       err,
  output state_e     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // out_valid and the record fields hold steady until that transfer.
  state_e     state_q, state_d;
  logic [4:0] date_q, date_d;
  logic [3:0] mon_q, mon_d;
  logic [2:0] week_q, week_d;
  logic [3:0] rem_q, rem_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  logic       skip_q, skip_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  logic [3:0] step_mon;
  logic [2:0] step_week;
  logic       req_bad;

  month_step u_step (
    .mon_i       (mon_q),
    .week_i      (week_q),
    .next_mon_o  (step_mon),
    .next_week_o (step_week)
  );

  assign req_bad = (mon_q == 4'd0) || (mon_q > MON_DEC) ||
                   (date_q == 5'd0) || (date_q > days_in_month(mon_q)) ||
                   (week_q == WEEK_INVALID) || (rem_q == 4'd0);

  always_comb begin
    state_d = state_q;
    date_d  = date_q;
    mon_d   = mon_q;
    week_d  = week_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    valid_d = valid_q;
    skip_d  = skip_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid && ready_q) begin
          date_d  = start_date;
          mon_d   = start_mon;
          week_d  = start_week;
          rem_d   = start_count;
          ready_d = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (req_bad) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
          skip_d  = 1'b0;
          last_d  = (rem_q == 4'd1);
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            skip_d  = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Weekday advances by the month being left, skipped or not.
            mon_d  = step_mon;
            week_d = step_week;
            rem_d  = rem_q - 4'd1;
            skip_d = (date_q > days_in_month(step_mon));
            last_d = (rem_q == 4'd2);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      date_q  <= 5'd0;
      mon_q   <= 4'd0;
      week_q  <= 3'd0;
      rem_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      date_q  <= date_d;
      mon_q   <= mon_d;
      week_q  <= week_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      skip_q  <= skip_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign start_ready = ready_q;
  assign out_valid   = valid_q;
  assign out_mon     = mon_q;
  assign out_week    = week_q;
  assign out_skip    = skip_q;
  assign out_last    = last_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_month_walker.sv
// Directed bench for month_walker: walks, year wrap, skipped dates, rejects,
// backpressure with busy start requests, and reset in the middle of a walk.
module tb_month_walker;
  import cal_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [4:0] start_date = '0;
  logic [3:0] start_mon = '0;
  logic [2:0] start_week = '0;
  logic [3:0] start_count = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_mon;
  logic [2:0] out_week;
  logic       out_skip;
  logic       out_last;
  logic       err;
  state_e     dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  month_walker dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_date  (start_date),
    .start_mon   (start_mon),
    .start_week  (start_week),
    .start_count (start_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mon     (out_mon),
    .out_week    (out_week),
    .out_skip    (out_skip),
    .out_last    (out_last),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [3:0] m, input logic [2:0] w,
                           input logic s, input logic l);
    check({tag, ".valid"}, 16'(out_valid), 16'd1);
    check({tag, ".mon"},   16'(out_mon),   16'(m));
    check({tag, ".week"},  16'(out_week),  16'(w));
    check({tag, ".skip"},  16'(out_skip),  16'(s));
    check({tag, ".last"},  16'(out_last),  16'(l));
    check({tag, ".err"},   16'(err),       16'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 16'(out_valid),   16'd0);
    check({tag, ".ready"}, 16'(start_ready), 16'd1);
    check({tag, ".state"}, 16'(dbg_state),   16'(ST_IDLE));
  endtask

  // Presents a request for one cycle; the accepting edge is the next tick.
  task automatic send(input logic [4:0] d, input logic [3:0] m,
                      input logic [2:0] w, input logic [3:0] c);
    start_date  = d;
    start_mon   = m;
    start_week  = w;
    start_count = c;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic check_in_check(input string tag);
    check({tag, ".chk_valid"}, 16'(out_valid),   16'd0);
    check({tag, ".chk_ready"}, 16'(start_ready), 16'd0);
    check({tag, ".chk_err"},   16'(err),         16'd0);
    check({tag, ".chk_state"}, 16'(dbg_state),   16'(ST_CHECK));
  endtask

  logic [4:0] rj_date [4] = '{5'd15, 5'd31, 5'd15, 5'd15};
  logic [3:0] rj_mon  [4] = '{4'd13, 4'd4,  4'd4,  4'd4};
  logic [2:0] rj_week [4] = '{3'd3,  3'd3,  3'd7,  3'd3};
  logic [3:0] rj_cnt  [4] = '{4'd3,  4'd3,  4'd3,  4'd0};

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst.ready", 16'(start_ready), 16'd1);
    check("rst.valid", 16'(out_valid),   16'd0);
    check("rst.err",   16'(err),         16'd0);
    check("rst.mon",   16'(out_mon),     16'd0);
    check("rst.week",  16'(out_week),    16'd0);
    check("rst.skip",  16'(out_skip),    16'd0);
    check("rst.last",  16'(out_last),    16'd0);
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    // Basic walk: 15th of Jan on weekday 3, three records.
    send(5'd15, 4'd1, 3'd3, 4'd3);
    check_in_check("basic");
    tick();
    check_rec("basic.r1", 4'd1, 3'd3, 1'b0, 1'b0);
    tick();
    check_rec("basic.r2", 4'd2, 3'd6, 1'b0, 1'b0);
    tick();
    check_rec("basic.r3", 4'd3, 3'd6, 1'b0, 1'b1);
    tick();
    check_idle("basic.end");

    // Year wrap from November.
    send(5'd10, 4'd11, 3'd0, 4'd3);
    check_in_check("wrap");
    tick();
    check_rec("wrap.r1", 4'd11, 3'd0, 1'b0, 1'b0);
    tick();
    check_rec("wrap.r2", 4'd12, 3'd2, 1'b0, 1'b0);
    tick();
    check_rec("wrap.r3", 4'd1, 3'd5, 1'b0, 1'b1);
    tick();
    check_idle("wrap.end");

    // Rejected requests: err pulse two cycles after accept, with start_ready.
    for (int i = 0; i < 4; i++) begin
      send(rj_date[i], rj_mon[i], rj_week[i], rj_cnt[i]);
      check_in_check($sformatf("rej%0d", i));
      tick();
      check($sformatf("rej%0d.err", i),   16'(err),         16'd1);
      check($sformatf("rej%0d.ready", i), 16'(start_ready), 16'd1);
      check($sformatf("rej%0d.valid", i), 16'(out_valid),   16'd0);
      tick();
      check($sformatf("rej%0d.err_off", i), 16'(err),       16'd0);
      check_idle($sformatf("rej%0d.end", i));
    end

    // Backpressure on record 2 with a start request pulsed while busy.
    send(5'd5, 4'd6, 3'd2, 4'd3);
    tick();
    check_rec("bp.r1", 4'd6, 3'd2, 1'b0, 1'b0);
    tick();
    check_rec("bp.r2", 4'd7, 3'd4, 1'b0, 1'b0);
    out_ready   = 1'b0;
    start_date  = 5'd1;
    start_mon   = 4'd1;
    start_week  = 3'd1;
    start_count = 4'd1;
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_rec($sformatf("bp.hold%0d", i), 4'd7, 3'd4, 1'b0, 1'b0);
      check($sformatf("bp.hold%0d.ready", i), 16'(start_ready), 16'd0);
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    tick();
    check_rec("bp.r3", 4'd8, 3'd0, 1'b0, 1'b1);
    tick();
    check_idle("bp.end");
    tick();
    check_idle("bp.no_start");
    check("bp.no_err", 16'(err), 16'd0);

    // Reset during record 2, then a fresh walk with a skipped month.
    send(5'd15, 4'd1, 3'd3, 4'd3);
    tick();
    tick();
    check_rec("mid.r2", 4'd2, 3'd6, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid.valid", 16'(out_valid),   16'd0);
    check("mid.ready", 16'(start_ready), 16'd1);
    check("mid.mon",   16'(out_mon),     16'd0);
    check("mid.week",  16'(out_week),    16'd0);
    check("mid.last",  16'(out_last),    16'd0);
    tick();
    rst = 1'b0;
    tick();
    check_idle("mid.after");

    send(5'd31, 4'd1, 3'd1, 4'd3);
    check_in_check("skip");
    tick();
    check_rec("skip.r1", 4'd1, 3'd1, 1'b0, 1'b0);
    tick();
    check_rec("skip.r2", 4'd2, 3'd4, 1'b1, 1'b0);
    tick();
    check_rec("skip.r3", 4'd3, 3'd4, 1'b0, 1'b1);
    tick();
    check_idle("skip.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
